sw_debounce: RTL



---
 rtl/sigma_board_pkg.sv | 15 +
 rtl/sw_debounce_bit.sv | 104 ++++++++++
 rtl/sw_debounce.sv | 44 ++++
 3 files changed

// File: rtl/sigma_board_pkg.sv
// sigma_board_pkg: board-level constants shared by NEXYS4-DDR glue logic.
//   SW_DEBOUNCE_CYCLES_100M : switch debounce window for the 100 MHz system clock (10 ms)
//   SW_DEBOUNCE_CYCLES_SIM  : short debounce window for simulation builds
//   db_state_e              : per-bit debouncer state, IDLE (s2 == db) / PEND (s2 != db, counting)
package sigma_board_pkg;

  localparam int unsigned SW_DEBOUNCE_CYCLES_100M = 1000000;
  localparam int unsigned SW_DEBOUNCE_CYCLES_SIM  = 8;

  typedef enum logic {
    DB_IDLE = 1'b0,
    DB_PEND = 1'b1
  } db_state_e;

endpackage

// File: rtl/sw_debounce_bit.sv
// sw_debounce_bit: one switch bit -- 2-flop synchronizer, stability counter,
// IDLE/PEND state machine and registered rise/fall strobes.
//   clk_i   in  system clock
//   rstn_i  in  synchronous active-low reset
//   raw_i   in  asynchronous switch pin
//   sw_o    out debounced level (registered)
//   rise_o  out one-cycle pulse in the cycle sw_o first shows 1
//   fall_o  out one-cycle pulse in the cycle sw_o first shows 0
// STABLE_CYCLES must be >= 2.
module sw_debounce_bit
  import sigma_board_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = SW_DEBOUNCE_CYCLES_100M,
  parameter logic        RESET_VAL     = 1'b0
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic raw_i,
  output logic sw_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             s1;
  logic             s2;
  db_state_e        state;
  db_state_e        state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             db_nxt;
  logic             rise_nxt;
  logic             fall_nxt;
  logic             mismatch;
  logic             done;

  assign mismatch = s2 ^ sw_o;
  assign done     = (cnt == CNT_LAST);

  // Synchronizer; cleared on reset so the fill is repeated after reset.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      s1 <= RESET_VAL;
      s2 <= RESET_VAL;
    end else begin
      s1 <= raw_i;
      s2 <= s1;
    end
  end

  // State register plus the registered datapath (counter, level, strobes).
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state  <= DB_IDLE;
      cnt    <= '0;
      sw_o   <= RESET_VAL;
      rise_o <= 1'b0;
      fall_o <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      sw_o   <= db_nxt;
      rise_o <= rise_nxt;
      fall_o <= fall_nxt;
    end
  end

  // Next state.
  always_comb begin
    state_nxt = state;
    case (state)
      DB_IDLE: if (mismatch) state_nxt = DB_PEND;
      DB_PEND: if (!mismatch || done) state_nxt = DB_IDLE;
      default: state_nxt = DB_IDLE;
    endcase
  end

  // Datapath next values. In IDLE cnt is always 0, and because
  // STABLE_CYCLES >= 2 the first mismatching cycle can never complete the count.
  always_comb begin
    cnt_nxt  = '0;
    db_nxt   = sw_o;
    rise_nxt = 1'b0;
    fall_nxt = 1'b0;
    case (state)
      DB_IDLE: begin
        if (mismatch) cnt_nxt = CNT_W'(1);
      end
      DB_PEND: begin
        if (mismatch && done) begin
          db_nxt   = s2;
          rise_nxt = s2;
          fall_nxt = ~s2;
        end else if (mismatch) begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: cnt_nxt = '0;
    endcase
  end

endmodule

// File: rtl/sw_debounce.sv
// sw_debounce: per-bit synchronizer/debouncer for the board slide switches.
//   clk_i      in  system clock (PLL output), the only clock
//   rstn_i     in  synchronous active-low reset
//   raw_i      in  [WIDTH] asynchronous switch pins
//   sw_o       out [WIDTH] debounced switch levels
//   rise_o     out [WIDTH] one-cycle pulse when a sw_o bit goes 0->1
//   fall_o     out [WIDTH] one-cycle pulse when a sw_o bit goes 1->0
//   any_chg_o  out OR of all rise/fall strobes
// A level change is accepted once the synchronized pin has disagreed with
// sw_o for STABLE_CYCLES consecutive cycles (STABLE_CYCLES >= 2).
module sw_debounce
  import sigma_board_pkg::*;
#(
  parameter int unsigned      WIDTH         = 16,
  parameter int unsigned      STABLE_CYCLES = SW_DEBOUNCE_CYCLES_100M,
  parameter logic [WIDTH-1:0] RESET_VAL     = '0
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] sw_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic             any_chg_o
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sw_debounce_bit #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .RESET_VAL    (RESET_VAL[i])
    ) u_bit (
      .clk_i (clk_i),
      .rstn_i(rstn_i),
      .raw_i (raw_i[i]),
      .sw_o  (sw_o[i]),
      .rise_o(rise_o[i]),
      .fall_o(fall_o[i])
    );
  end

  // Strobes are flops, so this is a pure OR of registered signals.
  assign any_chg_o = |(rise_o | fall_o);

endmodule
